// File: rtl/scl_gen_pkg.sv
// Shared definitions for the SDR SCL generator: FSM state encoding, default phase lengths
// and the length-select helper used when a programmed length is zero.
package scl_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } scl_state_e;

    localparam int unsigned PP_LOW_DFLT  = 2;
    localparam int unsigned PP_HIGH_DFLT = 2;
    localparam int unsigned OD_LOW_DFLT  = 63;
    localparam int unsigned OD_HIGH_DFLT = 62;

    function automatic int unsigned sel_len(input int unsigned len, input int unsigned dflt);
        return (len == 0) ? dflt : len;
    endfunction

endpackage

// File: rtl/scl_phase_counter.sv
// Loadable phase down-counter with freeze; flags expiry and announces mid-point arrival one cycle early.
// Latency: load/step takes effect on the next clock; mid_next is combinational from load/freeze.
// Backpressure: freeze holds the count indefinitely; load always wins over freeze.
module scl_phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_sdr_ctrl_clk,
    input  logic             i_sdr_ctrl_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_len,
    input  logic             freeze,
    output logic             zero,
    output logic             mid_next
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] mid_q;
    logic [CNT_W-1:0] mid_d;
    logic             step;

    always_comb begin
        cnt_d = cnt_q;
        mid_d = mid_q;
        step  = 1'b0;
        if (load) begin
            cnt_d = load_len - CNT_W'(1);
            mid_d = load_len >> 1;
        end else if (!freeze && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            step  = 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

    // Only a fresh arrival at the mid value counts, so a frozen count never re-fires the strobe.
    assign mid_next = (load || step) && (cnt_d == mid_d);

    always_ff @(posedge i_sdr_ctrl_clk or posedge i_sdr_ctrl_rst) begin
        if (i_sdr_ctrl_rst) begin
            cnt_q <= '0;
            mid_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mid_q <= mid_d;
        end
    end

endmodule

// File: rtl/scl_gen_param.sv
// SCL generator: programmable PP/OD high/low phases with edge pulses and mid-phase strobes.
// Latency: every output is registered, one clock after the deciding cycle.
// Backpressure: stall holds SCL low (freezing LOW count), idle parks SCL high, cas forces a fall.
module scl_gen_param
    import scl_gen_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PP_LOW_RST  = PP_LOW_DFLT,
    parameter int unsigned PP_HIGH_RST = PP_HIGH_DFLT,
    parameter int unsigned OD_LOW_RST  = OD_LOW_DFLT,
    parameter int unsigned OD_HIGH_RST = OD_HIGH_DFLT
) (
    input  logic             i_sdr_ctrl_clk,
    input  logic             i_sdr_ctrl_rst,
    input  logic             i_sdr_scl_gen_pp_od,
    input  logic [CNT_W-1:0] i_pp_low_cnt,
    input  logic [CNT_W-1:0] i_pp_high_cnt,
    input  logic [CNT_W-1:0] i_od_low_cnt,
    input  logic [CNT_W-1:0] i_od_high_cnt,
    input  logic             i_scl_gen_stall,
    input  logic             i_sdr_ctrl_scl_idle,
    input  logic             i_timer_cas,
    output logic             o_scl,
    output logic             o_scl_pos_edge,
    output logic             o_scl_neg_edge,
    output logic             o_scl_mid_high,
    output logic             o_scl_mid_low
);

    scl_state_e       st_q;
    scl_state_e       st_d;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] load_len;
    logic             load;
    logic             freeze;
    logic             to_low;
    logic             to_high;
    logic             cnt_zero;
    logic             mid_next;

    always_comb begin
        if (i_sdr_scl_gen_pp_od) begin
            low_len  = CNT_W'(sel_len(32'(i_pp_low_cnt), PP_LOW_RST));
            high_len = CNT_W'(sel_len(32'(i_pp_high_cnt), PP_HIGH_RST));
        end else begin
            low_len  = CNT_W'(sel_len(32'(i_od_low_cnt), OD_LOW_RST));
            high_len = CNT_W'(sel_len(32'(i_od_high_cnt), OD_HIGH_RST));
        end
    end

    always_comb begin
        st_d     = st_q;
        load     = 1'b0;
        load_len = low_len;
        freeze   = 1'b0;
        to_low   = 1'b0;
        to_high  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                freeze = 1'b1;
                if (i_scl_gen_stall || i_timer_cas || !i_sdr_ctrl_scl_idle) begin
                    to_low = 1'b1;
                end
            end
            ST_HIGH: begin
                if (i_scl_gen_stall || i_timer_cas) begin
                    to_low = 1'b1;
                end else if (cnt_zero) begin
                    if (i_sdr_ctrl_scl_idle) begin
                        st_d   = ST_IDLE;
                        freeze = 1'b1;
                    end else begin
                        to_low = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (i_scl_gen_stall) begin
                    freeze = 1'b1;
                end else if (cnt_zero) begin
                    to_high = 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (to_low) begin
            st_d     = ST_LOW;
            load     = 1'b1;
            load_len = low_len;
        end
        if (to_high) begin
            st_d     = ST_HIGH;
            load     = 1'b1;
            load_len = high_len;
        end
    end

    scl_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .i_sdr_ctrl_clk (i_sdr_ctrl_clk),
        .i_sdr_ctrl_rst (i_sdr_ctrl_rst),
        .load           (load),
        .load_len       (load_len),
        .freeze         (freeze),
        .zero           (cnt_zero),
        .mid_next       (mid_next)
    );

    always_ff @(posedge i_sdr_ctrl_clk or posedge i_sdr_ctrl_rst) begin
        if (i_sdr_ctrl_rst) begin
            st_q           <= ST_IDLE;
            o_scl          <= 1'b1;
            o_scl_pos_edge <= 1'b0;
            o_scl_neg_edge <= 1'b0;
            o_scl_mid_high <= 1'b0;
            o_scl_mid_low  <= 1'b0;
        end else begin
            st_q           <= st_d;
            o_scl          <= (st_d != ST_LOW);
            o_scl_pos_edge <= to_high;
            o_scl_neg_edge <= to_low;
            o_scl_mid_high <= !i_scl_gen_stall && mid_next && (st_d == ST_HIGH);
            o_scl_mid_low  <= !i_scl_gen_stall && mid_next && (st_d == ST_LOW);
        end
    end

endmodule
